counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
- Round-robin scheduler that shares the team's single 4-bit up-counter between NREQ requesters.
- Each requester asks for a count run of a given length.
- The block arbitrates the requests, clears the counter, enables it until the requested value is reached, then reports completion to the winner.
- It sits between the requester agents and the counter. It drives the counter's active-high synchronous clear and active-high enable, and reads back the counter output.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, counter width in bits; run length range 0..2^W-1

Ports:
clock  input  1  single clock; all logic on posedge clock
reset  input  1  synchronous, active-low reset (sampled on posedge clock)
req  input  NREQ  per-requester run request; level, held until done or abort
len  input  NREQ*W  run length per requester, slice i = len[i*W +: W]
cnt_value  input  W  current counter output
cnt_clear  output  1  active-high synchronous clear to counter
cnt_enable  output  1  active-high count enable to counter
grant  output  NREQ  one-hot owner of the counter, 0 when idle
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, run finished normally
abort  output  1  one-cycle pulse, owner dropped req before finishing
done_id  output  clog2(NREQ)  index of the requester for done/abort; valid with the pulse

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; grant=0; cnt_clear=0; cnt_enable=0; done=0; abort=0; done_id=0; busy=0; rr pointer last=NREQ-1, so requester 0 has highest priority after reset.
- Reset has priority over every other event, including mid-run. The counter is not cleared by reset; the next run's CLEAR handles that.
- FSM states: IDLE, CLEAR, RUN, FIN.
- IDLE:
  - If req!=0, pick the first asserted bit searching last+1, last+2, ... (mod NREQ).
  - Register grant=onehot(winner), tgt=len slice of winner, last=winner. Go to CLEAR.
  - len is sampled only at this edge; later changes are ignored.
- CLEAR (exactly 1 cycle): cnt_clear=1, cnt_enable=0. Go to RUN.
- RUN:
  - cnt_enable is combinational: 1 when cnt_value!=tgt, else 0.
  - When cnt_value==tgt, go to FIN with done=1 next cycle.
  - A run of length L spends L+1 cycles in RUN. Counter stops exactly at tgt with no overshoot.
  - tgt=0: first RUN cycle sees 0, enable is never asserted.
- FIN (1 cycle): done=1, done_id=winner, grant cleared. Go to IDLE.
- Abort: if req[owner]==0 in CLEAR or RUN, cnt_enable=0 that cycle. Next cycle abort=1, done_id=owner, grant=0, state=IDLE. The counter holds its partial value.
- The owner must deassert req on the cycle after done, or it is re-arbitrated under round-robin as a new request.
- Latency from req seen in IDLE to done pulse = L+3 cycles (grant edge, CLEAR, L+1 RUN, then FIN output). The next grant is earliest 1 cycle after FIN.
- Simultaneous events:
  - New requests arriving during busy wait; no preemption.
  - Abort and cnt_value==tgt in the same cycle: done wins. Done takes precedence because the run completed.
- Invariants: cnt_clear and cnt_enable are never both 1. grant is one-hot or zero. done and abort are never both 1.

Test Plan:
- Reset then req=4'b0001, len0=5 -> grant=0001 next cycle, cnt_clear 1 cycle, cnt_enable high 5 cycles, counter stops at 5, done pulse with done_id=0 at cycle 8 after req.
- req=4'b1111 held, all len=2 -> grants in order 0,1,2,3,0. One done per grant, each 5 cycles apart plus 1 idle cycle.
- req0 with len0=0 -> cnt_enable never asserted, done 3 cycles after grant, cnt_value=0.
- req2 with len2=15 -> counter reaches 15 with no wrap to 0, done_id=2.
- req1 len1=10, drop req1 when cnt_value=4 -> enable low that cycle, abort pulse next, counter holds 4 or 5, grant=0.
- Assert reset (0) while in RUN with cnt_value=7 -> next cycle all outputs 0, state IDLE. Next req3 and req0 together -> req0 granted first.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin arbiter that lends one shared W-bit up-counter to NREQ requesters,
// running it from zero up to the winner's requested length and reporting done/abort.
module counter_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   len,
    input  logic [W-1:0]        cnt_value,
    output logic                cnt_clear,
    output logic                cnt_enable,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                done,
    output logic                abort,
    output logic [IW-1:0]       done_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [W-1:0]      tgt_q, tgt_d;
    logic [IW-1:0]     last_q, last_d;
    logic              clear_q, clear_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [IW-1:0]     win;
    logic              owner_req;
    logic              hit;

    // Round-robin search starting just after the previous winner
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = last_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign owner_req = req[last_q];
    assign hit       = (cnt_value == tgt_q);

    // Next-state and output decode; completion outranks a same-cycle abort
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tgt_d      = tgt_q;
        last_d     = last_q;
        clear_d    = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        done_id_d  = done_id_q;
        cnt_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NREQ'(1) << win;
                    tgt_d   = len[32'(win)*W +: W];
                    last_d  = win;
                    clear_d = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!owner_req) begin
                    abort_d   = 1'b1;
                    done_id_d = last_q;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hit) begin
                    done_d    = 1'b1;
                    done_id_d = last_q;
                    grant_d   = '0;
                    state_d   = FIN;
                end else if (!owner_req) begin
                    abort_d   = 1'b1;
                    done_id_d = last_q;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State register; the counter itself is deliberately left alone by reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            tgt_q     <= '0;
            last_q    <= IW'(NREQ - 1);
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            done_id_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tgt_q     <= tgt_d;
            last_q    <= last_d;
            clear_q   <= clear_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
        end
    end

    assign cnt_clear = clear_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios then random traffic, checked every
// cycle against a transaction-level model of grant/run/finish timing.
module tb_counter_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 4;
    localparam int unsigned IW   = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   len;
    logic [W-1:0]        cnt_value = '0;
    logic                cnt_clear;
    logic                cnt_enable;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                done;
    logic                abort;
    logic [IW-1:0]       done_id;
    bit                  live = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model: owner (-1 when free), cycles since grant, target, last winner, counter
    int m_owner, m_age, m_tgt, m_last, m_cnt, m_done_id;
    bit m_fin, m_done, m_abort, m_rst;

    counter_sched #(.NREQ(NREQ), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .len        (len),
        .cnt_value  (cnt_value),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .abort      (abort),
        .done_id    (done_id)
    );

    always #5 clock = ~clock;

    // The shared counter being scheduled
    always @(posedge clock) begin
        if (live) begin
            if (cnt_clear === 1'b1)       cnt_value <= '0;
            else if (cnt_enable === 1'b1) cnt_value <= cnt_value + 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NREQ*W-1:0] pack(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    // One clock cycle: apply inputs, compare against model, advance model over the edge
    task automatic step(input bit rst_n, input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] l);
        int  e_grant;
        bit  e_clr, e_en, fnd;
        int  w;
        @(negedge clock);
        reset = rst_n;
        req   = r;
        len   = l;
        #1;
        e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_clr   = (m_owner >= 0) && (m_age == 0);
        e_en    = (m_owner >= 0) && (m_age >= 1) && (m_cnt != m_tgt) && r[m_owner];
        check("grant", 32'(grant), e_grant);
        check("busy", 32'(busy), 32'((m_owner >= 0) || m_fin));
        check("cnt_clear", 32'(cnt_clear), 32'(e_clr));
        check("cnt_enable", 32'(cnt_enable), 32'(e_en));
        check("done", 32'(done), 32'(m_done));
        check("abort", 32'(abort), 32'(m_abort));
        check("cnt_value", 32'(cnt_value), m_cnt);
        if (m_done || m_abort || m_rst) check("done_id", 32'(done_id), m_done_id);

        m_done  = 1'b0;
        m_abort = 1'b0;
        m_rst   = 1'b0;
        if (!rst_n) begin
            m_owner   = -1;
            m_fin     = 1'b0;
            m_done_id = 0;
            m_last    = NREQ - 1;
            m_rst     = 1'b1;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_owner < 0) begin
            if (r != '0) begin
                fnd = 1'b0;
                w   = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!fnd && r[(m_last + k) % NREQ]) begin
                        fnd = 1'b1;
                        w   = (m_last + k) % NREQ;
                    end
                end
                m_owner = w;
                m_last  = w;
                m_tgt   = int'((l >> (w * W)) & 16'hF);
                m_age   = 0;
            end
        end else if (m_age >= 1 && m_cnt == m_tgt) begin
            m_done    = 1'b1;
            m_done_id = m_owner;
            m_owner   = -1;
            m_fin     = 1'b1;
        end else if (!r[m_owner]) begin
            m_abort   = 1'b1;
            m_done_id = m_owner;
            m_owner   = -1;
        end else begin
            m_age++;
        end
        if (e_clr)     m_cnt = 0;
        else if (e_en) m_cnt = (m_cnt + 1) % (1 << W);
    endtask

    initial begin
        logic [NREQ-1:0] r;
        reset = 1'b0;
        req   = '0;
        len   = '0;
        repeat (2) @(posedge clock);
        live      = 1'b1;
        m_owner   = -1;
        m_age     = 0;
        m_tgt     = 0;
        m_last    = NREQ - 1;
        m_cnt     = 0;
        m_done_id = 0;
        m_fin     = 1'b0;
        m_done    = 1'b0;
        m_abort   = 1'b0;
        m_rst     = 1'b1;
        step(1'b0, '0, '0);

        // Single run of length 5
        repeat (10) step(1'b1, 4'b0001, pack(5, 0, 0, 0));
        repeat (2)  step(1'b1, 4'b0000, '0);

        // All requesters held, length 2: round-robin rotation
        repeat (26) step(1'b1, 4'b1111, pack(2, 2, 2, 2));
        repeat (2)  step(1'b1, 4'b0000, '0);

        // Zero-length run
        repeat (5) step(1'b1, 4'b0001, pack(0, 0, 0, 0));
        repeat (2) step(1'b1, 4'b0000, '0);

        // Full-range run must stop at 15 without wrapping
        repeat (19) step(1'b1, 4'b0100, pack(0, 0, 15, 0));
        repeat (2)  step(1'b1, 4'b0000, '0);

        // Abort when the counter shows 4
        step(1'b1, 4'b0010, pack(0, 10, 0, 0));
        for (int k = 0; k < 30 && !(m_owner == 1 && m_cnt == 4); k++)
            step(1'b1, 4'b0010, pack(0, 10, 0, 0));
        step(1'b1, 4'b0000, pack(0, 10, 0, 0));
        repeat (3) step(1'b1, 4'b0000, '0);

        // Reset in the middle of a run, then requester 0 must win over 3
        step(1'b1, 4'b0001, pack(12, 0, 0, 0));
        for (int k = 0; k < 30 && !(m_owner == 0 && m_cnt == 7); k++)
            step(1'b1, 4'b0001, pack(12, 0, 0, 0));
        step(1'b0, 4'b0001, pack(12, 0, 0, 0));
        repeat (12) step(1'b1, 4'b1001, pack(3, 0, 0, 3));
        repeat (2)  step(1'b1, 4'b0000, '0);

        // Random traffic with occasional drops and resets
        r = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r[i]) begin
                    if ($urandom_range(0, 29) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 4) == 0) begin
                    r[i] = 1'b1;
                end
            end
            step(($urandom_range(0, 299) != 0), r, NREQ*W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
